// File: rtl/ecc_apb_driver_if.sv
// APB bus between the ECC job driver (master) and the ECC register bank (slave).
//   PADDR   - register address
//   PSEL    - transfer select
//   PENABLE - access phase marker
//   PWRITE  - write strobe (this master only ever writes)
//   PWDATA  - write data
interface ecc_apb_driver_if #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
);
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_WORD-1:0]       PWDATA;

  modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA);
  modport slave  (input  PADDR, PSEL, PENABLE, PWRITE, PWDATA);
endinterface

// File: rtl/ecc_apb_driver.sv
// APB initiator for the ECC encoder/decoder register bank.
// Takes one job at a time, writes DATA_IN, CODEWORD_WIDTH, NOISE (full-channel
// mode only) and finally CTRL (which starts the ECC block), waits for
// operation_done under a watchdog, and returns the captured result.
//   clk, rst                 - clock, asynchronous active-low reset
//   req_valid/req_ready      - job handshake; req_mode/width/data/noise fields
//   apb                      - APB master bus
//   operation_done           - ECC completion pulse with data_out/num_of_errors
//   res_valid/res_ready      - result handshake
//   res_data/errors/status   - captured result; status 00 ok, 01 timeout, 10 bad mode
module ecc_apb_driver #(
  parameter int                         AMBA_WORD           = 32,
  parameter int                         AMBA_ADDR_WIDTH     = 20,
  parameter int                         DATA_WIDTH          = 32,
  parameter logic [AMBA_ADDR_WIDTH-1:0] CTRL_ADDR           = 'h00,
  parameter logic [AMBA_ADDR_WIDTH-1:0] DATA_IN_ADDR        = 'h04,
  parameter logic [AMBA_ADDR_WIDTH-1:0] CODEWORD_WIDTH_ADDR = 'h08,
  parameter logic [AMBA_ADDR_WIDTH-1:0] NOISE_ADDR          = 'h0C,
  parameter int                         TIMEOUT             = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_mode,
  input  logic [AMBA_WORD-1:0]  req_width,
  input  logic [AMBA_WORD-1:0]  req_data,
  input  logic [AMBA_WORD-1:0]  req_noise,
  ecc_apb_driver_if.master      apb,
  input  logic                  operation_done,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic [1:0]            num_of_errors,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [1:0]            res_errors,
  output logic [1:0]            res_status
);

  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] MODE_FULL = 2'd2;
  localparam logic [1:0] MODE_BAD  = 2'd3;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BADMODE = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {R_DATA, R_WIDTH, R_NOISE, R_CTRL} reg_t;

  state_t state, state_nx;
  reg_t   reg_q, reg_nx;

  logic [1:0]           mode_q;
  logic [AMBA_WORD-1:0] width_q, data_q, noise_q;
  logic [CNT_W-1:0]     wd_cnt;
  logic                 wd_expired;
  logic                 accept;

  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign accept     = (state == S_IDLE) && req_valid;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      reg_q <= R_DATA;
    end else begin
      state <= state_nx;
      reg_q <= reg_nx;
    end
  end

  // Next-state logic; reg_q walks through the register write order
  always_comb begin
    state_nx = state;
    reg_nx   = reg_q;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          reg_nx   = R_DATA;
          state_nx = (req_mode == MODE_BAD) ? S_RESP : S_SETUP;
        end
      end
      S_SETUP: state_nx = S_ACCESS;
      S_ACCESS: begin
        unique case (reg_q)
          R_DATA: begin
            reg_nx   = R_WIDTH;
            state_nx = S_SETUP;
          end
          R_WIDTH: begin
            reg_nx   = (mode_q == MODE_FULL) ? R_NOISE : R_CTRL;
            state_nx = S_SETUP;
          end
          R_NOISE: begin
            reg_nx   = R_CTRL;
            state_nx = S_SETUP;
          end
          R_CTRL: state_nx = S_WAIT;
        endcase
      end
      S_WAIT: begin
        if (operation_done || wd_expired) state_nx = S_RESP;
      end
      S_RESP: begin
        if (res_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Job latch, watchdog and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= '0;
      width_q    <= '0;
      data_q     <= '0;
      noise_q    <= '0;
      wd_cnt     <= '0;
      res_data   <= '0;
      res_errors <= '0;
      res_status <= '0;
    end else begin
      if (accept) begin
        mode_q  <= req_mode;
        width_q <= req_width;
        data_q  <= req_data;
        noise_q <= req_noise;
        if (req_mode == MODE_BAD) begin
          res_data   <= '0;
          res_errors <= '0;
          res_status <= ST_BADMODE;
        end
      end

      wd_cnt <= (state == S_WAIT) ? wd_cnt + 1'b1 : '0;

      // done wins over an expiring watchdog on the same cycle
      if (state == S_WAIT) begin
        if (operation_done) begin
          res_data   <= data_out;
          res_errors <= num_of_errors;
          res_status <= ST_OK;
        end else if (wd_expired) begin
          res_data   <= '0;
          res_errors <= '0;
          res_status <= ST_TIMEOUT;
        end
      end
    end
  end

  // Outputs decoded from state; bus fields are zero outside a transfer
  always_comb begin
    req_ready   = (state == S_IDLE);
    res_valid   = (state == S_RESP);
    apb.PSEL    = (state == S_SETUP) || (state == S_ACCESS);
    apb.PENABLE = (state == S_ACCESS);
    apb.PWRITE  = apb.PSEL;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    if (apb.PSEL) begin
      unique case (reg_q)
        R_DATA: begin
          apb.PADDR  = DATA_IN_ADDR;
          apb.PWDATA = data_q;
        end
        R_WIDTH: begin
          apb.PADDR  = CODEWORD_WIDTH_ADDR;
          apb.PWDATA = width_q;
        end
        R_NOISE: begin
          apb.PADDR  = NOISE_ADDR;
          apb.PWDATA = noise_q;
        end
        R_CTRL: begin
          apb.PADDR  = CTRL_ADDR;
          apb.PWDATA = AMBA_WORD'(mode_q);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_apb_driver.sv
module tb_ecc_apb_driver;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_mode;
  logic [31:0] req_width, req_data, req_noise;
  logic        operation_done;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_errors;
  logic [1:0]  res_status;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ecc_apb_driver_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) apb_bus ();

  ecc_apb_driver #(
    .AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_width(req_width), .req_data(req_data), .req_noise(req_noise),
    .apb(apb_bus),
    .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_errors(res_errors), .res_status(res_status)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] width;
    logic [31:0] data;
    logic [31:0] noise;
    int          done_at;   // WAIT cycle index carrying operation_done, -1 = never
    logic [31:0] dout;
    logic [1:0]  nerr;
    logic [1:0]  exp_status;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic do_job(input int idx, input vec_t v, input bit handshake);
    logic [19:0] waddr[4];
    logic [31:0] wdata[4];
    int n;
    chk($sformatf("v%0d req_ready idle", idx), req_ready, 1);
    req_mode  = v.mode;
    req_width = v.width;
    req_data  = v.data;
    req_noise = v.noise;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_mode  = v.mode ^ 2'd1;
    req_width = 32'hFFFF_0001;
    req_data  = 32'hDEAD_BEEF;
    req_noise = 32'h0BAD_0BAD;
    chk($sformatf("v%0d req_ready busy", idx), req_ready, 0);
    if (v.mode == 2'd3) begin
      chk($sformatf("v%0d bad PSEL", idx), apb_bus.PSEL, 0);
    end else begin
      n = 0;
      waddr[n] = 20'h04; wdata[n] = v.data;  n++;
      waddr[n] = 20'h08; wdata[n] = v.width; n++;
      if (v.mode == 2'd2) begin
        waddr[n] = 20'h0C; wdata[n] = v.noise; n++;
      end
      waddr[n] = 20'h00; wdata[n] = {30'd0, v.mode}; n++;
      for (int i = 0; i < n; i++) begin
        chk($sformatf("v%0d w%0d setup PSEL", idx, i), apb_bus.PSEL, 1);
        chk($sformatf("v%0d w%0d setup PENABLE", idx, i), apb_bus.PENABLE, 0);
        chk($sformatf("v%0d w%0d setup PADDR", idx, i), apb_bus.PADDR, waddr[i]);
        chk($sformatf("v%0d w%0d setup PWDATA", idx, i), apb_bus.PWDATA, wdata[i]);
        @(negedge clk);
        chk($sformatf("v%0d w%0d access PSEL", idx, i), apb_bus.PSEL, 1);
        chk($sformatf("v%0d w%0d access PENABLE", idx, i), apb_bus.PENABLE, 1);
        chk($sformatf("v%0d w%0d access PWRITE", idx, i), apb_bus.PWRITE, 1);
        chk($sformatf("v%0d w%0d access PADDR", idx, i), apb_bus.PADDR, waddr[i]);
        chk($sformatf("v%0d w%0d access PWDATA", idx, i), apb_bus.PWDATA, wdata[i]);
        @(negedge clk);
      end
      chk($sformatf("v%0d wait PSEL", idx), apb_bus.PSEL, 0);
      chk($sformatf("v%0d wait PADDR", idx), apb_bus.PADDR, 0);
      chk($sformatf("v%0d wait PWDATA", idx), apb_bus.PWDATA, 0);
      for (int k = 0; k < TIMEOUT; k++) begin
        chk($sformatf("v%0d wait%0d res_valid", idx, k), res_valid, 0);
        operation_done = (k == v.done_at);
        data_out       = (k == v.done_at) ? v.dout : (32'hBAD0_0000 | k);
        num_of_errors  = (k == v.done_at) ? v.nerr : 2'd2;
        @(negedge clk);
        operation_done = 1'b0;
        if (k == v.done_at) break;
      end
    end
    chk($sformatf("v%0d res_valid", idx), res_valid, 1);
    chk($sformatf("v%0d res_data", idx), res_data, v.exp_data);
    chk($sformatf("v%0d res_errors", idx), res_errors, v.exp_err);
    chk($sformatf("v%0d res_status", idx), res_status, v.exp_status);
    if (handshake) begin
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk($sformatf("v%0d post res_valid", idx), res_valid, 0);
      chk($sformatf("v%0d post req_ready", idx), req_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic seen_valid, seen_sel;

    //        mode  width        data          noise   done dout          nerr st    exp_data      err
    vecs[0] = '{2'd0, 32'h0,     32'h5A,       32'hFF, 3,   32'h1234,     2'd0, 2'b00, 32'h1234,     2'd0};
    vecs[1] = '{2'd2, 32'h1A,    32'hCAFE,     32'h1,  4,   32'hBEEF,     2'd1, 2'b00, 32'hBEEF,     2'd1};
    vecs[2] = '{2'd1, 32'h8,     32'h3C,       32'h7,  2,   32'hA5,       2'd2, 2'b00, 32'hA5,       2'd2};
    vecs[3] = '{2'd3, 32'h10,    32'h99,       32'h3,  -1,  32'h0,        2'd0, 2'b10, 32'h0,        2'd0};
    vecs[4] = '{2'd0, 32'h20,    32'h1357,     32'h0,  -1,  32'h0,        2'd0, 2'b01, 32'h0,        2'd0};
    vecs[5] = '{2'd2, 32'h1F,    32'h2468,     32'h5,  15,  32'h77,       2'd3, 2'b00, 32'h77,       2'd3};

    rst = 1'b0;
    req_valid = 1'b0; req_mode = '0; req_width = '0; req_data = '0; req_noise = '0;
    operation_done = 1'b0; data_out = '0; num_of_errors = '0; res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst req_ready", req_ready, 1);
    chk("rst PSEL", apb_bus.PSEL, 0);
    chk("rst PENABLE", apb_bus.PENABLE, 0);
    chk("rst PWRITE", apb_bus.PWRITE, 0);
    chk("rst PADDR", apb_bus.PADDR, 0);
    chk("rst PWDATA", apb_bus.PWDATA, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst res_data", res_data, 0);
    chk("rst res_errors", res_errors, 0);
    chk("rst res_status", res_status, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_job(i, vecs[i], 1'b1);
      @(negedge clk);
    end

    // Result held while res_ready stays low; new request and stray done pulses ignored
    do_job(10, vecs[0], 1'b0);
    req_mode = 2'd1; req_width = 32'h4; req_data = 32'h11; req_noise = 32'h0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      operation_done = i[0];
      data_out = 32'hFFFF_FFFF;
      num_of_errors = 2'd3;
      @(negedge clk);
      chk($sformatf("hold%0d res_valid", i), res_valid, 1);
      chk($sformatf("hold%0d res_data", i), res_data, 32'h1234);
      chk($sformatf("hold%0d res_errors", i), res_errors, 0);
      chk($sformatf("hold%0d res_status", i), res_status, 0);
      chk($sformatf("hold%0d req_ready", i), req_ready, 0);
      chk($sformatf("hold%0d PSEL", i), apb_bus.PSEL, 0);
    end
    operation_done = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("hs res_valid", res_valid, 0);
    chk("hs req_ready", req_ready, 1);
    chk("hs PSEL", apb_bus.PSEL, 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("next PSEL", apb_bus.PSEL, 1);
    chk("next PADDR", apb_bus.PADDR, 20'h04);
    chk("next PWDATA", apb_bus.PWDATA, 32'h11);

    // Walk to the CTRL ACCESS cycle of that mode-1 job and reset there
    repeat (5) @(negedge clk);
    chk("ctrl PENABLE", apb_bus.PENABLE, 1);
    chk("ctrl PADDR", apb_bus.PADDR, 20'h00);
    chk("ctrl PWDATA", apb_bus.PWDATA, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("async PSEL", apb_bus.PSEL, 0);
    chk("async PENABLE", apb_bus.PENABLE, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 1'b0;
    seen_sel = 1'b0;
    for (int i = 0; i < 24; i++) begin
      operation_done = (i == 3);
      @(negedge clk);
      seen_valid |= res_valid;
      seen_sel |= apb_bus.PSEL;
    end
    operation_done = 1'b0;
    chk("after rst no res_valid", seen_valid, 0);
    chk("after rst no PSEL", seen_sel, 0);
    chk("after rst req_ready", req_ready, 1);

    do_job(20, vecs[2], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecc_apb_driver.md
# ecc_apb_driver

APB initiator that drives the ECC encoder/decoder's register bank on behalf of a job-level client. It accepts one job at a time (mode, codeword width, data, noise) and issues the required APB writes, with the CTRL write last so that it triggers start. It then waits for `operation_done`, captures `data_out` and `num_of_errors`, and returns them on a valid/ready result port. A watchdog reports jobs whose `operation_done` never arrives.

## Interface
Parameters:
- `AMBA_WORD`, 32, APB data width
- `AMBA_ADDR_WIDTH`, 20, APB address width
- `DATA_WIDTH`, 32, ECC data width
- `CTRL_ADDR`, 'h00, CTRL register address
- `DATA_IN_ADDR`, 'h04, DATA_IN register address
- `CODEWORD_WIDTH_ADDR`, 'h08, CODEWORD_WIDTH register address
- `NOISE_ADDR`, 'h0C, NOISE register address
- `TIMEOUT`, 16, maximum WAIT cycles before timeout (≥2)

Ports:
- `clk`  in  1  clock, single clock domain
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  job offered
- `req_ready`  out  1  job accepted when high with `req_valid`
- `req_mode`  in  2  0 = encode, 1 = decode, 2 = full channel, 3 = illegal
- `req_width`  in  AMBA_WORD  CODEWORD_WIDTH value
- `req_data`  in  AMBA_WORD  DATA_IN value
- `req_noise`  in  AMBA_WORD  NOISE value
- `PADDR`  out  AMBA_ADDR_WIDTH  APB address
- `PSEL`  out  1  APB select
- `PENABLE`  out  1  APB enable
- `PWRITE`  out  1  APB write; always 1 while `PSEL` is high
- `PWDATA`  out  AMBA_WORD  APB write data
- `operation_done`  in  1  one-cycle pulse from the ECC block
- `data_out`  in  DATA_WIDTH  ECC result
- `num_of_errors`  in  2  ECC error count
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumed when high with `res_valid`
- `res_data`  out  DATA_WIDTH  captured `data_out`
- `res_errors`  out  2  captured `num_of_errors`
- `res_status`  out  2  00 = ok, 01 = timeout, 10 = bad mode

## Operation
- States: IDLE, SETUP, ACCESS, WAIT, RESP.
- Reset values:
  - All outputs are 0 except `req_ready`, which is 1.
  - FSM goes to IDLE.
  - Reset asserted mid-job drops `PSEL`/`PENABLE` immediately; the job is lost and no result is produced.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch all req fields.
  - Mode 3 goes straight to RESP with status 10, `res_data` = 0, `res_errors` = 0, and no APB traffic.
  - Any other mode goes to SETUP for the first write.
- Write sequence, each register in order:
  - DATA_IN, then CODEWORD_WIDTH, then NOISE (written only when mode = 2), then CTRL (`PWDATA` = {0, mode}).
  - Each write takes one SETUP cycle (`PSEL` = 1, `PENABLE` = 0), then one ACCESS cycle (`PSEL` = 1, `PENABLE` = 1).
  - `PADDR`/`PWDATA` are stable across both cycles.
  - There is no wait-state input; every transfer is exactly 2 cycles.
  - Back-to-back writes: `PSEL` stays high and `PENABLE` drops to 0 for the next SETUP.
- After the CTRL ACCESS cycle: `PSEL`, `PENABLE` = 0; `PADDR` and `PWDATA` return to 0; go to WAIT.
- WAIT:
  - A watchdog counter starts at 0 and increments each cycle.
  - `operation_done` = 1 captures `data_out`/`num_of_errors` into `res_data`/`res_errors`, sets status 00, and goes to RESP.
  - If the counter reaches TIMEOUT−1 without done: status 01, data/errors 0, go to RESP.
  - Done arriving on that same final cycle takes priority and gives status 00.
- RESP:
  - `res_valid` = 1 and all `res_*` are held stable until `res_ready`.
  - On the handshake cycle, return to IDLE. `res_valid` = 0 and `req_ready` = 1 from the next cycle.
  - No new job is accepted while in RESP.
- `operation_done` outside WAIT is ignored; res registers are unchanged.
- `req_*` changes after acceptance have no effect.

## Timing
- Job accept edge = E0. `req_ready` falls after E0.
- First SETUP runs E0–E1.
- Modes 0/1: 3 writes, CTRL ACCESS ends at E6, WAIT begins at E6.
- Mode 2: 4 writes, WAIT begins at E8.
- ECC done latency: 2 cycles after start for modes 0/1, 4 cycles for mode 2.
- Done sampled at WAIT edge Wn: `res_valid` = 1 from Wn.
- Bad mode: `res_valid` = 1 the cycle after E0.
- Timeout: `res_valid` rises TIMEOUT cycles after WAIT entry.
- Minimum job-to-job spacing: result handshake cycle, then 1 IDLE cycle.

## Test plan
- Encode job (mode 0, width 'h0, data 'h5A, noise 'hFF) with done stubbed 3 cycles into WAIT, `data_out` 'h1234:
  - APB sequence is 04←'h5A, 08←'h0, 00←'h0; no NOISE write.
  - Result 'h1234, errors 0, status 00.
- Full channel (mode 2, noise 'h1):
  - Four writes in order 04, 08, 0C←'h1, 00←'h2, each with exact SETUP/ACCESS `PENABLE` pattern.
  - `num_of_errors` 1 captured.
- Mode 3 request:
  - `PSEL` never rises.
  - `res_valid` the next cycle, status 10.
- No `operation_done` with TIMEOUT = 16:
  - Status 01 after 16 WAIT cycles, data 0.
  - Done injected on cycle 15 instead gives status 00.
- `res_ready` held low for 5 cycles while `req_valid` = 1 and stray `operation_done` pulses arrive:
  - `res_*` stable, `req_ready` stays 0.
  - The next job starts only after the handshake.
- Reset asserted during the CTRL ACCESS cycle:
  - `PSEL`/`PENABLE` go to 0 asynchronously, `req_ready` = 1 after release.
  - No `res_valid` appears.
